// File: rtl/lvdc_timing_sequencer_if.sv
// Signal bundle between the LVDC timing sequencer and its surrounding logic.
// The master drives the clock phase and the run/step/error controls; the slave is the sequencer.
interface lvdc_timing_sequencer_if;
  logic       CK_P;
  logic       RUN;
  logic       STEP_REQ;
  logic       ERR_CLR;
  logic [2:0] FAULT_INJ;
  logic [1:0] PHASE;
  logic [3:0] BIT_TIME;
  logic       SYL;
  logic       PHASE_STROBE;
  logic       WORD_STROBE;
  logic       HALTED;
  logic       STEP_ACK;
  logic       TMR_ERR;

  modport master (
    output CK_P, RUN, STEP_REQ, ERR_CLR, FAULT_INJ,
    input  PHASE, BIT_TIME, SYL, PHASE_STROBE, WORD_STROBE, HALTED, STEP_ACK, TMR_ERR
  );

  modport slave (
    input  CK_P, RUN, STEP_REQ, ERR_CLR, FAULT_INJ,
    output PHASE, BIT_TIME, SYL, PHASE_STROBE, WORD_STROBE, HALTED, STEP_ACK, TMR_ERR
  );
endinterface

// File: rtl/lvdc_timing_sequencer.sv
// Phase / bit-time / syllable sequencer driven by the voted CK_P level, with
// run/halt/single-step control and triple-voted counter state.
module lvdc_timing_sequencer #(
  parameter int N_BITS      = 14,
  parameter int SYNC_STAGES = 2
) (
  input logic                    CLK,
  input logic                    RSTN,
  lvdc_timing_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP, ST_ACK} state_t;

  localparam logic [3:0] BT_LAST = 4'(N_BITS);
  // Replica layout: {PHASE[1:0], BIT_TIME[3:0], SYL}
  localparam logic [6:0] CNT_RST = {2'd0, 4'd1, 1'b0};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [6:0]             rep_q [3];
  logic [6:0]             rep_d [3];
  logic [6:0]             rep_v [3];
  logic [6:0]             vote;
  logic [6:0]             cnt_next;
  logic                   ps_q, ps_d;
  logic                   ws_q, ws_d;
  logic                   err_q, err_d;
  logic                   tick, counting, wrap, mismatch;
  logic [1:0]             ph;
  logic [3:0]             bt;
  logic                   syl;

  function automatic logic [6:0] maj3(input logic [6:0] a, input logic [6:0] b,
                                      input logic [6:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.CK_P};
    hist_d = sync_q[SYNC_STAGES-1];
    tick   = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // FAULT_INJ models an upset on a replica as seen by the voter for one cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rep_v[i] = rep_q[i] ^ {5'd0, bus.FAULT_INJ[i], 1'b0};
    end
    vote     = maj3(rep_v[0], rep_v[1], rep_v[2]);
    mismatch = (rep_v[0] != vote) | (rep_v[1] != vote) | (rep_v[2] != vote);
    ph       = vote[6:5];
    bt       = vote[4:1];
    syl      = vote[0];
  end

  assign counting = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign wrap     = counting && tick && (ph == 2'd3) && (bt == BT_LAST) && syl;

  // All replicas reload from the vote each cycle so a stray replica self-heals.
  always_comb begin
    cnt_next = vote;
    if (counting && tick) begin
      cnt_next[6:5] = ph + 2'd1;
      if (ph == 2'd3) begin
        if (bt == BT_LAST) begin
          cnt_next[4:1] = 4'd1;
          cnt_next[0]   = ~syl;
        end else begin
          cnt_next[4:1] = bt + 4'd1;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      rep_d[i] = cnt_next;
    end
    ps_d  = counting && tick;
    ws_d  = wrap;
    err_d = mismatch | (err_q & ~bus.ERR_CLR);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (bus.RUN)           state_d = ST_RUN;
        else if (bus.STEP_REQ) state_d = ST_STEP;
      end
      ST_RUN:  if (!bus.RUN && wrap) state_d = ST_HALT;
      ST_STEP: if (wrap)             state_d = ST_ACK;
      ST_ACK:  if (!bus.STEP_REQ)    state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_HALT;
      sync_q  <= '0;
      hist_q  <= 1'b0;
      for (int i = 0; i < 3; i++) rep_q[i] <= CNT_RST;
      ps_q    <= 1'b0;
      ws_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      for (int i = 0; i < 3; i++) rep_q[i] <= rep_d[i];
      ps_q    <= ps_d;
      ws_q    <= ws_d;
      err_q   <= err_d;
    end
  end

  assign bus.PHASE        = ph;
  assign bus.BIT_TIME     = bt;
  assign bus.SYL          = syl;
  assign bus.PHASE_STROBE = ps_q;
  assign bus.WORD_STROBE  = ws_q;
  assign bus.HALTED       = (state_q == ST_HALT);
  assign bus.STEP_ACK     = (state_q == ST_ACK);
  assign bus.TMR_ERR      = err_q;

endmodule

// File: tb/tb_lvdc_timing_sequencer.sv
// Scoreboard bench for lvdc_timing_sequencer: each counted CK_P pulse queues the
// expected post-tick state; a negedge monitor checks it whenever PHASE_STROBE fires.
module tb_lvdc_timing_sequencer;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  lvdc_timing_sequencer_if bus ();

  lvdc_timing_sequencer #(.N_BITS(14), .SYNC_STAGES(2)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0] ph;
    logic [3:0] bt;
    logic       syl;
    logic       ws;
    logic       halted;
    logic       ack;
  } exp_t;

  exp_t       sbq [$];
  int         total  = 0;
  int         bad    = 0;
  int         ps_cnt = 0;
  int         ws_cnt = 0;
  int         ps0, ws0;
  logic [1:0] m_ph;
  logic [3:0] m_bt;
  logic       m_syl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumes one queued expectation per PHASE_STROBE.
  always @(negedge CLK) begin
    exp_t       e;
    logic [9:0] act;
    if (RSTN) begin
      if (bus.WORD_STROBE) chk("ws_with_ps", {31'd0, bus.PHASE_STROBE}, 32'd1);
      if (bus.PHASE_STROBE) begin
        ps_cnt++;
        if (bus.WORD_STROBE) ws_cnt++;
        act = {bus.PHASE, bus.BIT_TIME, bus.SYL, bus.WORD_STROBE, bus.HALTED, bus.STEP_ACK};
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got ph/bt/syl/ws/halt/ack=0x%0h want no strobe", act);
        end else begin
          e = sbq.pop_front();
          chk("strobe_state", {22'd0, act}, {22'd0, e});
        end
      end
    end
  end

  // One CK_P pulse, 4 cycles high and 4 low; counted pulses queue the expected state.
  task automatic pulse(input bit counted, input bit halt_w, input bit ack_w);
    exp_t e;
    logic w;
    if (counted) begin
      w = (m_ph == 2'd3) && (m_bt == 4'd14) && m_syl;
      if (m_ph == 2'd3) begin
        if (m_bt == 4'd14) begin
          m_bt  = 4'd1;
          m_syl = ~m_syl;
        end else begin
          m_bt = m_bt + 4'd1;
        end
      end
      m_ph     = m_ph + 2'd1;
      e.ph     = m_ph;
      e.bt     = m_bt;
      e.syl    = m_syl;
      e.ws     = w;
      e.halted = w & halt_w;
      e.ack    = w & ack_w;
      sbq.push_back(e);
    end
    bus.CK_P = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    bus.CK_P = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic pulses(input int n, input bit counted, input bit halt_w, input bit ack_w);
    for (int i = 0; i < n; i++) pulse(counted, halt_w, ack_w);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge CLK);
    #1;
    chk(name, sbq.size(), 0);
  endtask

  task automatic chk_cnt(input string name, input logic [1:0] ph, input logic [3:0] bt,
                         input logic syl);
    chk(name, {25'd0, bus.PHASE, bus.BIT_TIME, bus.SYL}, {25'd0, ph, bt, syl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CK_P = 1'b0; bus.RUN = 1'b0; bus.STEP_REQ = 1'b0;
    bus.ERR_CLR = 1'b0; bus.FAULT_INJ = 3'b000;
    m_ph = 2'd0; m_bt = 4'd1; m_syl = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    chk_cnt("reset_counters", 2'd0, 4'd1, 1'b0);
    chk("reset_halted", {31'd0, bus.HALTED}, 32'd1);
    chk("reset_ack", {31'd0, bus.STEP_ACK}, 32'd0);
    chk("reset_strobes", {30'd0, bus.PHASE_STROBE, bus.WORD_STROBE}, 32'd0);
    chk("reset_err", {31'd0, bus.TMR_ERR}, 32'd0);
    RSTN = 1'b1;

    pulses(3, 1'b0, 1'b0, 1'b0);
    chk_cnt("halted_ignores_ticks", 2'd0, 4'd1, 1'b0);

    // Free run, two full words.
    bus.RUN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("run_entered", {31'd0, bus.HALTED}, 32'd0);
    ps0 = ps_cnt; ws0 = ws_cnt;
    pulses(224, 1'b1, 1'b0, 1'b0);
    drain("drain_freerun");
    chk("freerun_phase_strobes", ps_cnt - ps0, 224);
    chk("freerun_word_strobes", ws_cnt - ws0, 2);
    chk_cnt("freerun_final", 2'd0, 4'd1, 1'b0);

    // Drop RUN mid-word; halt must land on the word wrap (86 ticks from 2/7/0).
    pulses(26, 1'b1, 1'b0, 1'b0);
    drain("drain_to_2_7_0");
    chk_cnt("at_2_7_0", 2'd2, 4'd7, 1'b0);
    bus.RUN = 1'b0;
    pulses(85, 1'b1, 1'b1, 1'b0);
    drain("drain_before_halt");
    chk("still_running", {31'd0, bus.HALTED}, 32'd0);
    pulses(1, 1'b1, 1'b1, 1'b0);
    drain("drain_halt");
    chk("halt_on_boundary", {31'd0, bus.HALTED}, 32'd1);
    pulses(2, 1'b0, 1'b0, 1'b0);
    chk_cnt("halt_holds", 2'd0, 4'd1, 1'b0);

    // Single-word step handshake.
    bus.STEP_REQ = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("step_entered", {31'd0, bus.HALTED}, 32'd0);
    pulses(112, 1'b1, 1'b0, 1'b1);
    drain("drain_step");
    chk("step_ack_high", {31'd0, bus.STEP_ACK}, 32'd1);
    pulses(2, 1'b0, 1'b0, 1'b0);
    chk("ack_holds", {31'd0, bus.STEP_ACK}, 32'd1);
    chk_cnt("ack_ignores_ticks", 2'd0, 4'd1, 1'b0);
    bus.STEP_REQ = 1'b0;
    @(posedge CLK);
    #1;
    chk("ack_released", {31'd0, bus.STEP_ACK}, 32'd0);
    chk("halt_after_step", {31'd0, bus.HALTED}, 32'd1);

    // RUN beats STEP_REQ.
    bus.RUN = 1'b1; bus.STEP_REQ = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("prio_not_halted", {31'd0, bus.HALTED}, 32'd0);
    pulses(4, 1'b1, 1'b0, 1'b0);
    drain("drain_prio");
    chk("prio_no_ack", {31'd0, bus.STEP_ACK}, 32'd0);
    bus.STEP_REQ = 1'b0;

    // TMR fault masking and sticky error flag.
    chk("err_clear_before_fault", {31'd0, bus.TMR_ERR}, 32'd0);
    bus.FAULT_INJ = 3'b010;
    @(posedge CLK);
    #1;
    bus.FAULT_INJ = 3'b000;
    chk_cnt("fault_masked", m_ph, m_bt, m_syl);
    @(posedge CLK);
    #1;
    chk("err_set", {31'd0, bus.TMR_ERR}, 32'd1);
    chk_cnt("fault_healed", m_ph, m_bt, m_syl);
    bus.ERR_CLR = 1'b1;
    @(posedge CLK);
    #1;
    bus.ERR_CLR = 1'b0;
    chk("err_cleared", {31'd0, bus.TMR_ERR}, 32'd0);
    bus.FAULT_INJ = 3'b001; bus.ERR_CLR = 1'b1;
    @(posedge CLK);
    #1;
    bus.FAULT_INJ = 3'b000; bus.ERR_CLR = 1'b0;
    chk("set_beats_clear", {31'd0, bus.TMR_ERR}, 32'd1);
    @(posedge CLK);
    #1;
    chk("err_sticky", {31'd0, bus.TMR_ERR}, 32'd1);
    pulses(3, 1'b1, 1'b0, 1'b0);
    drain("drain_after_fault");

    // Asynchronous reset in the middle of a word.
    bus.CK_P = 1'b1;
    @(posedge CLK);
    #3;
    RSTN = 1'b0;
    #1;
    chk_cnt("midword_reset_counters", 2'd0, 4'd1, 1'b0);
    chk("midword_reset_halted", {31'd0, bus.HALTED}, 32'd1);
    chk("midword_reset_err", {31'd0, bus.TMR_ERR}, 32'd0);
    chk("midword_reset_strobes", {30'd0, bus.PHASE_STROBE, bus.WORD_STROBE}, 32'd0);
    bus.CK_P = 1'b0; bus.RUN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    m_ph = 2'd0; m_bt = 4'd1; m_syl = 1'b0;
    pulses(2, 1'b0, 1'b0, 1'b0);
    chk_cnt("post_reset_halted_counts", 2'd0, 4'd1, 1'b0);
    drain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
